// File: rtl/ram_arbiter2_pkg.sv
// rtl/ram_arbiter2_pkg.sv - shared types and default widths for the RAM arbiter
// Contents: FSM state enum, requester port id enum, default word/address widths.
package ram_arb_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 7;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/ram_arbiter2_if.sv
// rtl/ram_arbiter2_if.sv - one requester's request/response bundle
// Signals: valid/ready/we/addr/wdata (request), rvalid/rdata (response).
// Modports: master = requester side, slave = arbiter side.
interface ram_arbiter2_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/ram_arbiter2_rr.sv
// rtl/ram_arbiter2_rr.sv - two-way round-robin grant logic (module rr_arbiter2)
// Ports: req[1:0] (bit 0 = A, bit 1 = B), last_grant (port granted last),
//        grant[1:0] one-hot winner, zero when nothing requests. Combinational.
import ram_arb_pkg::*;

module rr_arbiter2 (
  input  logic [1:0] req,
  input  port_e      last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Tie: the port that did not win last time goes first.
      2'b11:   grant = (last_grant == PORT_B) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter2.sv
// rtl/ram_arbiter2.sv - round-robin sequencer of two requesters onto one single-port RAM
// Ports: clk, rst (async, active high); a, b requester bundles (slave side);
//        ram_we/ram_address/ram_d to the RAM, ram_q combinational read data back;
//        busy high while an access is in flight.
import ram_arb_pkg::*;

module ram_arbiter2 #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_arbiter2_if.slave         a,
  ram_arbiter2_if.slave         b,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy
);

  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_ACCESS = ACCESS;

  logic [0:0]            state;
  port_e                 last_grant;
  port_e                 cmd_port;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  a_rvalid_q, b_rvalid_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic [1:0]            grant;
  logic                  in_idle;

  rr_arbiter2 u_rr (
    .req        ({b.valid, a.valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign in_idle  = (state == ST_IDLE);
  assign a.ready  = in_idle & grant[0];
  assign b.ready  = in_idle & grant[1];
  assign a.rvalid = a_rvalid_q;
  assign a.rdata  = a_rdata_q;
  assign b.rvalid = b_rvalid_q;
  assign b.rdata  = b_rdata_q;

  // Address/data always come from the command registers so the RAM inputs
  // stay put between accesses; only the write enable is gated by state.
  // Because state resets asynchronously, ram_we drops the moment rst rises.
  assign ram_address = cmd_addr;
  assign ram_d       = cmd_wdata;
  assign ram_we      = (state == ST_ACCESS) & cmd_we;
  assign busy        = (state == ST_ACCESS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= PORT_B;
      cmd_port   <= PORT_A;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            cmd_port   <= grant[0] ? PORT_A : PORT_B;
            last_grant <= grant[0] ? PORT_A : PORT_B;
            cmd_we     <= grant[0] ? a.we    : b.we;
            cmd_addr   <= grant[0] ? a.addr  : b.addr;
            cmd_wdata  <= grant[0] ? a.wdata : b.wdata;
            state      <= ST_ACCESS;
          end
        end
        default: begin
          // Closing edge of the access: ram_q has had the full cycle to settle.
          if (cmd_port == PORT_A) begin
            a_rvalid_q <= 1'b1;
            if (!cmd_we) a_rdata_q <= ram_q;
          end else begin
            b_rvalid_q <= 1'b1;
            if (!cmd_we) b_rdata_q <= ram_q;
          end
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
